fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the asynchronous FIFO among NUM_REQ write-domain requesters.
- Lives in the wclk domain and drives the FIFO's write_enable/data_write; observes wfull and wHalf_full.
- Round-robin arbitration with burst lock. Half-full throttling restricts access to high-priority requesters.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 9, FIFO write data width
- MAX_BURST, 4, max accepted writes per grant before forced rotation (>=1)
- HIPRI_MASK, 4'b0001, requesters still eligible while wHalf_full=1 (width NUM_REQ)

Ports:
- wclk  in  1  write-domain clock, the only clock
- wrst_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester write request, held until granted
- req_data  in  NUM_REQ*DATA_WIDTH  flattened data; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- gnt  out  NUM_REQ  one-hot accept pulse; data of requester i consumed this cycle
- wfull  in  1  FIFO full flag
- wHalf_full  in  1  FIFO half-full flag
- write_enable  out  1  to FIFO
- data_write  out  DATA_WIDTH  to FIFO
- owner_id  out  $clog2(NUM_REQ)  current burst owner (valid when busy=1)
- busy  out  1  state==BURST
- stall_cnt  out  16  stall statistic (see Optional Feature)

Behaviour:
- Reset (async, wrst_n=0): state=IDLE, rr_ptr=NUM_REQ-1, owner_id=0, burst_cnt=0, busy=0, stall_cnt=0. write_enable, gnt and data_write are 0 because they decode from IDLE.
- Eligibility: eligible[i] = req[i] & (~wHalf_full | HIPRI_MASK[i]).
- IDLE:
  - write_enable=0, gnt=0.
  - If any eligible: next owner = first eligible index searching rr_ptr+1, rr_ptr+2, … modulo NUM_REQ. Go to BURST with burst_cnt=0.
  - This costs 1 arbitration cycle: first write to the FIFO happens at the earliest on cycle 2 after req rises.
- BURST:
  - accept = req[owner] & ~wfull & (~wHalf_full | HIPRI_MASK[owner]).
  - write_enable = accept (combinational); data_write = owner's req_data slice when accept, else 0; gnt[owner] = accept.
  - On accept: burst_cnt++.
  - wfull=1 with req[owner]=1: stall; hold state, burst_cnt, owner.
- BURST exits to IDLE (rr_ptr <= owner, burst_cnt <= 0) when any of these holds:
  - (a) req[owner]=0;
  - (b) accept with burst_cnt==MAX_BURST-1;
  - (c) wHalf_full=1 and owner not in HIPRI_MASK. Write is suppressed that cycle.
- Simultaneous conditions: exit conditions take priority over stall hold; (b) still performs the write.
- wfull is registered inside the FIFO. The arbiter never writes while wfull=1; the FIFO's own ~wfull gate remains as backstop.
- gnt is always one-hot or zero; never asserted in IDLE.
- Reset asserted mid-burst: immediate return to IDLE; no partial state retained; rr_ptr back to NUM_REQ-1.
- Requester contract: req_data is stable while req=1 and gnt=0. Dropping req before gnt is allowed; no write occurs.

Optional Feature:
- Macro: WR_ARB_STATS_EN.
- Defined: stall_cnt increments by 1 every BURST cycle with req[owner]=1 and wfull=1. Saturates at 16'hFFFF; cleared only by reset.
- Undefined: no counter logic; stall_cnt tied to 0. Port list identical both ways.

Test Plan:
- Single requester: req=4'b0010, data 9'h0A5, FIFO empty → busy=1 next cycle, owner_id=1, gnt=4'b0010 and write_enable=1 with data_write=9'h0A5 for 4 consecutive cycles. Then IDLE for 1 cycle and re-grant.
- All requesting: req=4'b1111 held, MAX_BURST=4 → owners in order 0,1,2,3,0. Exactly 4 gnt pulses each; 1 idle cycle between bursts.
- Full stall: owner 2 mid-burst, wfull=1 for 5 cycles → write_enable=0, burst_cnt held. With WR_ARB_STATS_EN, stall_cnt=5. Writes resume when wfull=0.
- Half-full throttle: req=4'b0011, wHalf_full=1, HIPRI_MASK=4'b0001 → only requester 0 is granted. Owner 1 mid-burst when wHalf_full rises → burst ends with no write that cycle.
- Requester drop: owner 3 drops req after 2 accepts → IDLE next cycle, rr_ptr=3, next grant searches from 0.
- Reset mid-burst: wrst_n low during BURST → busy=0, write_enable=0, gnt=0 immediately (asynchronous). First grant after release goes to the lowest-index eligible requester.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one FIFO write port among NUM_REQ requesters.
// Optional stall statistic enabled by defining WR_ARB_STATS_EN; otherwise stall_cnt reads 0.
module fifo_wr_arbiter #(
  parameter int                 NUM_REQ    = 4,
  parameter int                 DATA_WIDTH = 9,
  parameter int                 MAX_BURST  = 4,
  parameter logic [NUM_REQ-1:0] HIPRI_MASK = NUM_REQ'(1)
) (
  input  logic                          wclk,
  input  logic                          wrst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          wfull,
  input  logic                          wHalf_full,
  output logic                          write_enable,
  output logic [DATA_WIDTH-1:0]         data_write,
  output logic [$clog2(NUM_REQ)-1:0]    owner_id,
  output logic                          busy,
  output logic [15:0]                   stall_cnt
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   burst_cnt;
  logic [NUM_REQ-1:0] eligible;
  logic [PTR_W-1:0]   next_owner;
  logic               found;
  logic               in_burst;
  logic               owner_req;
  logic               owner_hipri;
  logic               accept;
  logic               exit_burst;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign eligible[gi] = req[gi] & (~wHalf_full | HIPRI_MASK[gi]);
      assign gnt[gi]      = accept & (owner_id == PTR_W'(gi));
    end
  endgenerate

  // Search starts just after the previous owner so every requester gets a turn.
  always_comb begin
    next_owner = '0;
    found      = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && eligible[(int'(rr_ptr) + k) % NUM_REQ]) begin
        next_owner = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
        found      = 1'b1;
      end
    end
  end

  assign in_burst     = (state == BURST);
  assign owner_req    = req[owner_id];
  assign owner_hipri  = HIPRI_MASK[owner_id];
  assign accept       = in_burst & owner_req & ~wfull & (~wHalf_full | owner_hipri);
  assign write_enable = accept;
  assign data_write   = accept ? req_data[owner_id*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign busy         = in_burst;

  // Exits win over a full-stall hold; a final burst write still goes through.
  assign exit_burst = ~owner_req
                    | (wHalf_full & ~owner_hipri)
                    | (accept & (burst_cnt == CNT_W'(MAX_BURST - 1)));

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state     <= IDLE;
      rr_ptr    <= PTR_W'(NUM_REQ - 1);
      owner_id  <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state     <= BURST;
            owner_id  <= next_owner;
            burst_cnt <= '0;
          end
        end
        BURST: begin
          if (exit_burst) begin
            state     <= IDLE;
            rr_ptr    <= owner_id;
            burst_cnt <= '0;
          end else if (accept) begin
            burst_cnt <= burst_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WR_ARB_STATS_EN
  logic [15:0] stall_reg;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      stall_reg <= '0;
    end else if (in_burst && owner_req && wfull && (stall_reg != 16'hFFFF)) begin
      stall_reg <= stall_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_reg;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: arbitration order, burst length, stall, throttle, drop and reset.
module tb_fifo_wr_arbiter;

  logic        wclk = 1'b0;
  logic        wrst_n;
  logic [3:0]  req;
  logic [35:0] req_data;
  logic [3:0]  gnt;
  logic        wfull;
  logic        wHalf_full;
  logic        write_enable;
  logic [8:0]  data_write;
  logic [1:0]  owner_id;
  logic        busy;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  logic [8:0] dval [4];

  fifo_wr_arbiter dut (
    .wclk(wclk), .wrst_n(wrst_n), .req(req), .req_data(req_data), .gnt(gnt),
    .wfull(wfull), .wHalf_full(wHalf_full), .write_enable(write_enable),
    .data_write(data_write), .owner_id(owner_id), .busy(busy), .stall_cnt(stall_cnt)
  );

  always #5 wclk = ~wclk;

  // busy, owner_id, gnt, write_enable, data_write
  wire [16:0] obs_vec  = {busy, owner_id, gnt, write_enable, data_write};
  wire [14:0] idle_vec = {busy, gnt, write_enable, data_write};

  function automatic logic [16:0] burst_exp(input int o, input bit wr);
    logic [3:0] g;
    logic [8:0] d;
    g = wr ? 4'(1 << o) : 4'b0000;
    d = wr ? dval[o] : 9'h000;
    return {1'b1, 2'(o), g, wr, d};
  endfunction

  task automatic do_reset();
    @(negedge wclk);
    wrst_n = 1'b0; req = 4'b0000; wfull = 1'b0; wHalf_full = 1'b0;
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge wclk);
    #1;
    checks++;
    if (idle_vec !== 15'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", idle_vec);
    end
    checks++;
    if (owner_id !== 2'd0) begin
      errors++; $display("FAIL reset_owner: got %0d expected 0", owner_id);
    end
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_stall: got %0d expected 0", stall_cnt);
    end
    @(negedge wclk); wrst_n = 1'b1;
    @(negedge wclk); #1;
    checks++;
    if (idle_vec !== 15'd0) begin
      errors++; $display("FAIL reset_idle_noreq: got %h expected 0", idle_vec);
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    logic [16:0] e;
    do_reset();
    @(negedge wclk); req = 4'b0010; #1;
    checks++;
    if (idle_vec !== 15'd0) begin
      errors++; $display("FAIL single_arb_cycle: got %h expected 0", idle_vec);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge wclk); #1;
      e = burst_exp(1, 1'b1);
      checks++;
      if (obs_vec !== e) begin
        errors++; $display("FAIL single_write%0d: got %h expected %h", c, obs_vec, e);
      end
    end
    @(negedge wclk); #1;
    checks++;
    if (idle_vec !== 15'd0) begin
      errors++; $display("FAIL single_gap: got %h expected 0", idle_vec);
    end
    @(negedge wclk); #1;
    e = burst_exp(1, 1'b1);
    checks++;
    if (obs_vec !== e) begin
      errors++; $display("FAIL single_regrant: got %h expected %h", obs_vec, e);
    end
    $display("test_single done");
  endtask

  task automatic test_round_robin();
    int seq [5] = '{0, 1, 2, 3, 0};
    logic [16:0] e;
    do_reset();
    @(negedge wclk); req = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      if (b != 0) @(negedge wclk);
      #1;
      checks++;
      if (idle_vec !== 15'd0) begin
        errors++; $display("FAIL rr_gap%0d: got %h expected 0", b, idle_vec);
      end
      for (int c = 0; c < 4; c++) begin
        @(negedge wclk); #1;
        e = burst_exp(seq[b], 1'b1);
        checks++;
        if (obs_vec !== e) begin
          errors++; $display("FAIL rr_burst%0d_write%0d: got %h expected %h", b, c, obs_vec, e);
        end
      end
    end
    $display("test_round_robin done");
  endtask

  task automatic test_full_stall();
    logic [16:0] e;
    logic [15:0] exp_stall;
`ifdef WR_ARB_STATS_EN
    exp_stall = 16'd5;
`else
    exp_stall = 16'd0;
`endif
    do_reset();
    @(negedge wclk); req = 4'b0100;
    for (int c = 0; c < 2; c++) begin
      @(negedge wclk); #1;
      e = burst_exp(2, 1'b1);
      checks++;
      if (obs_vec !== e) begin
        errors++; $display("FAIL stall_pre%0d: got %h expected %h", c, obs_vec, e);
      end
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge wclk); wfull = 1'b1; #1;
      e = burst_exp(2, 1'b0);
      checks++;
      if (obs_vec !== e) begin
        errors++; $display("FAIL stall_hold%0d: got %h expected %h", c, obs_vec, e);
      end
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge wclk); wfull = 1'b0; #1;
      e = burst_exp(2, 1'b1);
      checks++;
      if (obs_vec !== e) begin
        errors++; $display("FAIL stall_resume%0d: got %h expected %h", c, obs_vec, e);
      end
    end
    @(negedge wclk); #1;
    checks++;
    if (idle_vec !== 15'd0) begin
      errors++; $display("FAIL stall_burst_end: got %h expected 0", idle_vec);
    end
    checks++;
    if (stall_cnt !== exp_stall) begin
      errors++; $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt, exp_stall);
    end
    $display("test_full_stall done");
  endtask

  task automatic test_half_full();
    logic [16:0] e;
    do_reset();
    @(negedge wclk); req = 4'b0011; wHalf_full = 1'b1;
    for (int b = 0; b < 2; b++) begin
      if (b != 0) @(negedge wclk);
      #1;
      checks++;
      if (idle_vec !== 15'd0) begin
        errors++; $display("FAIL hf_gap%0d: got %h expected 0", b, idle_vec);
      end
      for (int c = 0; c < 4; c++) begin
        @(negedge wclk); #1;
        e = burst_exp(0, 1'b1);
        checks++;
        if (obs_vec !== e) begin
          errors++; $display("FAIL hf_only0_b%0d_w%0d: got %h expected %h", b, c, obs_vec, e);
        end
      end
    end
    do_reset();
    @(negedge wclk); req = 4'b0010;
    for (int c = 0; c < 2; c++) begin
      @(negedge wclk); #1;
      e = burst_exp(1, 1'b1);
      checks++;
      if (obs_vec !== e) begin
        errors++; $display("FAIL hf_owner1_w%0d: got %h expected %h", c, obs_vec, e);
      end
    end
    @(negedge wclk); wHalf_full = 1'b1; #1;
    e = burst_exp(1, 1'b0);
    checks++;
    if (obs_vec !== e) begin
      errors++; $display("FAIL hf_cut: got %h expected %h", obs_vec, e);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge wclk); #1;
      checks++;
      if (idle_vec !== 15'd0) begin
        errors++; $display("FAIL hf_blocked%0d: got %h expected 0", c, idle_vec);
      end
    end
    $display("test_half_full done");
  endtask

  task automatic test_drop();
    logic [16:0] e;
    do_reset();
    @(negedge wclk); req = 4'b1000;
    for (int c = 0; c < 2; c++) begin
      @(negedge wclk); #1;
      e = burst_exp(3, 1'b1);
      checks++;
      if (obs_vec !== e) begin
        errors++; $display("FAIL drop3_w%0d: got %h expected %h", c, obs_vec, e);
      end
    end
    @(negedge wclk); req = 4'b0000; #1;
    e = burst_exp(3, 1'b0);
    checks++;
    if (obs_vec !== e) begin
      errors++; $display("FAIL drop3_cut: got %h expected %h", obs_vec, e);
    end
    @(negedge wclk); req = 4'b1001; #1;
    checks++;
    if (idle_vec !== 15'd0) begin
      errors++; $display("FAIL drop3_idle: got %h expected 0", idle_vec);
    end
    @(negedge wclk); #1;
    e = burst_exp(0, 1'b1);
    checks++;
    if (obs_vec !== e) begin
      errors++; $display("FAIL drop3_next: got %h expected %h", obs_vec, e);
    end
    // rr_ptr must become 1 here, so the next search starts at 2 and picks 3 over 1
    do_reset();
    @(negedge wclk); req = 4'b0010;
    for (int c = 0; c < 2; c++) begin
      @(negedge wclk); #1;
      e = burst_exp(1, 1'b1);
      checks++;
      if (obs_vec !== e) begin
        errors++; $display("FAIL drop1_w%0d: got %h expected %h", c, obs_vec, e);
      end
    end
    @(negedge wclk); req = 4'b0000; #1;
    e = burst_exp(1, 1'b0);
    checks++;
    if (obs_vec !== e) begin
      errors++; $display("FAIL drop1_cut: got %h expected %h", obs_vec, e);
    end
    @(negedge wclk); req = 4'b1010; #1;
    checks++;
    if (idle_vec !== 15'd0) begin
      errors++; $display("FAIL drop1_idle: got %h expected 0", idle_vec);
    end
    @(negedge wclk); #1;
    e = burst_exp(3, 1'b1);
    checks++;
    if (obs_vec !== e) begin
      errors++; $display("FAIL drop1_next: got %h expected %h", obs_vec, e);
    end
    $display("test_drop done");
  endtask

  task automatic test_reset_mid_burst();
    logic [16:0] e;
    do_reset();
    @(negedge wclk); req = 4'b0100;
    @(negedge wclk); #1;
    e = burst_exp(2, 1'b1);
    checks++;
    if (obs_vec !== e) begin
      errors++; $display("FAIL rst_mid_pre: got %h expected %h", obs_vec, e);
    end
    @(negedge wclk); wrst_n = 1'b0; #1;
    checks++;
    if (idle_vec !== 15'd0) begin
      errors++; $display("FAIL rst_mid_async: got %h expected 0", idle_vec);
    end
    checks++;
    if (owner_id !== 2'd0) begin
      errors++; $display("FAIL rst_mid_owner: got %0d expected 0", owner_id);
    end
    @(negedge wclk); wrst_n = 1'b1; req = 4'b0110; #1;
    checks++;
    if (idle_vec !== 15'd0) begin
      errors++; $display("FAIL rst_mid_arb: got %h expected 0", idle_vec);
    end
    @(negedge wclk); #1;
    e = burst_exp(1, 1'b1);
    checks++;
    if (obs_vec !== e) begin
      errors++; $display("FAIL rst_mid_first_grant: got %h expected %h", obs_vec, e);
    end
    $display("test_reset_mid_burst done");
  endtask

  initial begin
    dval[0] = 9'h011; dval[1] = 9'h0A5; dval[2] = 9'h1C2; dval[3] = 9'h133;
    req_data = {dval[3], dval[2], dval[1], dval[0]};
    wrst_n = 1'b0; req = 4'b0000; wfull = 1'b0; wHalf_full = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_half_full();
    test_drop();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
